// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole round logic.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package mole_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GAP,
      UP,
      HIT,
      OVER
   } state_t;

   localparam int NUM_HOLES = 5;
   localparam int LFSR_W    = 8;

   // Hole 1..NUM_HOLES maps to keys[hole-1]; hole 0 (no mole) maps to no key.
   function automatic logic [NUM_HOLES-1:0] hole_key(input logic [2:0] hole);
      logic [NUM_HOLES-1:0] k;
      k = '0;
      if (hole != 3'd0 && hole <= 3'(NUM_HOLES))
         k[hole - 3'd1] = 1'b1;
      return k;
   endfunction

   // Pseudo-random hole in 1..NUM_HOLES, never repeating the previous hole.
   function automatic logic [2:0] pick_hole(input logic [LFSR_W-1:0] lfsr,
                                            input logic [2:0]        last);
      logic [2:0] h;
      h = 3'(lfsr % LFSR_W'(NUM_HOLES)) + 3'd1;
      if (h == last)
         h = (h == 3'(NUM_HOLES)) ? 3'd1 : h + 3'd1;
      return h;
   endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advancing every clock.
// Latency: new value every cycle; seed visible immediately out of reset.
// Backpressure: none, never stalls.
module mole_lfsr
   import mole_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [LFSR_W-1:0] state
);

   // Shift left, feeding back taps 8,6,5,4 into bit 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= SEED;
      else
         state <= {state[LFSR_W-2:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
   end

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: raises one mole, times it, scores hits, counts misses.
// Latency: all outputs registered; a valid key edge gives correct_whack one cycle later.
// Backpressure: none; tick/start/keys are sampled every cycle and never stalled.
module mole_round_ctrl
   import mole_pkg::*;
#(
   parameter int                MOLE_TICKS = 8,
   parameter int                GAP_TICKS  = 2,
   parameter int                MAX_MISSES = 3,
   parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'hA5,
   localparam int               MW         = $clog2(MAX_MISSES + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick,
   input  logic                 start,
   input  logic [NUM_HOLES-1:0] keys,
   output logic [2:0]           mole,
   output logic                 correct_whack,
   output logic [MW-1:0]        miss_count,
   output logic                 game_lose,
   output logic                 busy
);

   localparam int TMAX = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
   localparam int TW   = $clog2(TMAX + 1);

   state_t               state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [2:0]           mole_q, mole_d;
   logic [2:0]           last_q, last_d;
   logic [MW-1:0]        miss_q, miss_d;
   logic [NUM_HOLES-1:0] prev_keys_q;
   logic [NUM_HOLES-1:0] rise;
   logic [LFSR_W-1:0]    lfsr_state;
   logic [2:0]           picked;
   logic                 hit_ok;
   logic                 tick_last;
   logic [MW-1:0]        miss_inc;
   logic                 whack_q, lose_q, busy_q;

   mole_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .state (lfsr_state)
   );

   // Only a single freshly-pressed key matching the exposed hole scores;
   // held keys never re-trigger because only edges are looked at.
   assign rise      = keys & ~prev_keys_q;
   assign hit_ok    = (mole_q != 3'd0) && (rise == hole_key(mole_q));
   assign tick_last = tick && (timer_q == TW'(1));
   assign picked    = pick_hole(lfsr_state, last_q);
   assign miss_inc  = (miss_q == MW'(MAX_MISSES)) ? miss_q : miss_q + MW'(1);

   // Next-state and next-register values; a hit takes priority over a timeout tick.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      mole_d  = mole_q;
      last_d  = last_q;
      miss_d  = miss_q;
      case (state_q)
         IDLE, OVER: begin
            if (start) begin
               state_d = GAP;
               timer_d = TW'(GAP_TICKS);
               miss_d  = '0;
            end
         end
         GAP: begin
            if (tick_last) begin
               state_d = UP;
               mole_d  = picked;
               last_d  = picked;
               timer_d = TW'(MOLE_TICKS);
            end else if (tick) begin
               timer_d = timer_q - TW'(1);
            end
         end
         UP: begin
            if (hit_ok) begin
               state_d = HIT;
               mole_d  = 3'd0;
            end else if (tick_last) begin
               mole_d = 3'd0;
               miss_d = miss_inc;
               if (miss_inc == MW'(MAX_MISSES)) begin
                  state_d = OVER;
               end else begin
                  state_d = GAP;
                  timer_d = TW'(GAP_TICKS);
               end
            end else if (tick) begin
               timer_d = timer_q - TW'(1);
            end
         end
         HIT: begin
            state_d = GAP;
            timer_d = TW'(GAP_TICKS);
         end
         default: begin
            state_d = IDLE;
            mole_d  = 3'd0;
         end
      endcase
   end

   // State, round bookkeeping and registered status outputs derived from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         mole_q      <= 3'd0;
         last_q      <= 3'd0;
         miss_q      <= '0;
         prev_keys_q <= '0;
         whack_q     <= 1'b0;
         lose_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         mole_q      <= mole_d;
         last_q      <= last_d;
         miss_q      <= miss_d;
         prev_keys_q <= keys;
         whack_q     <= (state_d == HIT);
         lose_q      <= (state_d == OVER);
         busy_q      <= (state_d == GAP) || (state_d == UP) || (state_d == HIT);
      end
   end

   assign mole          = mole_q;
   assign correct_whack = whack_q;
   assign miss_count    = miss_q;
   assign game_lose     = lose_q;
   assign busy          = busy_q;

endmodule

// File: doc/mole_round_ctrl.md
# mole_round_ctrl

Round sequencer for the whack-a-mole game. It raises one mole at a time, chosen pseudo-randomly from five holes, and times the mole's exposure. It checks the keypad against the exposed mole and emits a one-cycle `correct_whack` pulse that drives the score counter. It also counts missed moles and asserts `game_lose` after `MAX_MISSES` misses. It sits between the keypad/tick-prescaler logic and the score counter/display.

## Interface
- `MOLE_TICKS`, default 8: ticks a mole stays up before it counts as missed (≥1).
- `GAP_TICKS`, default 2: ticks with no mole between rounds (≥1).
- `MAX_MISSES`, default 3: misses that end the game (≥1).
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst_n` in 1: reset, asynchronous and active-low.
- `tick` in 1: one-cycle game-time enable from the prescaler.
- `start` in 1: level or pulse; sampled only in IDLE and OVER.
- `keys` in 5: synchronised, debounced key levels. Bit order: {S, X, D, W, A}.
- `mole` out 3: exposed hole. 0 means none; 1..5 map to `keys[0]`..`keys[4]`.
- `correct_whack` out 1: one-cycle pulse per valid hit.
- `miss_count` out $clog2(MAX_MISSES+1): misses this game.
- `game_lose` out 1: high while in OVER.
- `busy` out 1: high in GAP, UP and HIT.

## Operation
- **Reset values:** state IDLE, `mole`=0, `correct_whack`=0, `miss_count`=0, `game_lose`=0, `busy`=0, timer=0, prev_keys=0, last_hole=0, LFSR=`LFSR_SEED`.
- **LFSR:** 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. Shifts every clk cycle in every state, never only on tick.
- **Hole pick:** hole = (LFSR mod 5) + 1. If this equals last_hole, use hole = (hole mod 5) + 1 instead. Store the result in last_hole.
- **Key edges:** rise = keys & ~prev_keys. prev_keys updates every cycle.
- **States:**
  - IDLE: `start`=1 → GAP. On entry, clear `miss_count` and load timer=`GAP_TICKS`.
  - GAP: each tick decrements timer. A tick while timer==1 → UP, with `mole`=picked hole and timer=`MOLE_TICKS`.
  - UP, valid hit: rise has exactly one bit set and it is bit `mole`-1 → HIT. `mole`=0.
  - UP, other key activity: any other nonzero rise is ignored. This covers a wrong key, or multiple keys rising in the same cycle.
  - UP, timeout: a tick while timer==1 with no valid hit → `mole`=0 and `miss_count`+1. If the new count equals `MAX_MISSES` → OVER, otherwise → GAP with timer=`GAP_TICKS`.
  - HIT: lasts exactly one cycle with `correct_whack`=1, then → GAP with timer=`GAP_TICKS`.
  - OVER: `game_lose`=1 and `mole`=0. `start`=1 → GAP with `miss_count`=0 and `game_lose` cleared.
- **Simultaneous events:** a valid hit and a timeout tick in the same cycle count as a hit; no miss is recorded. `start` is ignored in GAP, UP and HIT.
- **Miss counter:** saturates at `MAX_MISSES` and never wraps.
- **Reset mid-round:** the asynchronous reset drops `mole` and any `correct_whack` pulse in progress immediately.

## Timing
- All outputs are registered.
- A valid rising edge in cycle N gives `mole`=0 and `correct_whack`=1 in cycle N+1. `correct_whack`=0 again in N+2.
- The mole appears the cycle after the GAP-expiring tick.
- The mole is up for exactly `MOLE_TICKS` ticks.
- `game_lose` rises the cycle after the final timeout tick.
- A key held across a mole change does not hit the new mole, because edges only are counted.

## Structure
- Shared package `mole_pkg`:
  - state enum {IDLE, GAP, UP, HIT, OVER}.
  - NUM_HOLES=5.
  - The hole↔key index mapping.
- Sub-module `mole_lfsr`:
  - Parameters: seed.
  - Ports: clk, rst_n, 8-bit state output.
  - Shared with future difficulty logic.
- Timer width: $clog2(max(MOLE_TICKS, GAP_TICKS)+1).

## Test plan
- **Reset:** assert `rst_n`=0 mid-UP → all outputs 0 the same cycle, LFSR=8'hA5.
- **Valid hit:** start with `tick` every 4 cycles; after the 2nd tick `mole`=k. Rise `keys[k-1]` → next cycle `correct_whack`=1 for one cycle, `mole`=0, `miss_count`=0.
- **Wrong key:** with a mole up, rise the wrong key, then two keys together → no pulse. The mole times out after 8 ticks and `miss_count`=1.
- **Lose:** three timeouts → `miss_count`=3, `game_lose`=1, `busy`=0. `start` → `miss_count`=0 and `game_lose`=0.
- **Tie:** a valid edge in the same cycle as the expiring tick → `correct_whack`=1 and `miss_count` unchanged.
- **Held key / hole sequence:** hold the correct key across the round boundary → no hit on the new mole. Run 50 rounds → consecutive `mole` values always differ and all fall in 1..5.
